// File: rtl/arb8way16_pkg.sv
// Shared constants, state encoding and lane-slice helper for the 8-lane
// round-robin arbiter.
package arb8way16_pkg;

  localparam int N_LANES = 8;
  localparam int SEL_W   = 3;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  // Low bit of lane `lane` inside a packed vector of `width`-bit lanes.
  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/arb8way16_if.sv
// Requester-lane and downstream-channel bundle seen by the arbiter.
interface arb8way16_if #(
  parameter int WIDTH = 16
);
  import arb8way16_pkg::*;

  logic [N_LANES-1:0]       in_valid;
  logic [N_LANES*WIDTH-1:0] in_data;
  logic [N_LANES-1:0]       in_ready;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         out_data;
  logic [SEL_W-1:0]         out_src;

  // Arbiter side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_src
  );

  // Requesters plus consumer side.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_src
  );

endinterface

// File: rtl/arb8way16_rr_pick8.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping mod 8.
module rr_pick8
  import arb8way16_pkg::*;
(
  input  logic [N_LANES-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [N_LANES-1:0] gnt_onehot,
  output logic [SEL_W-1:0]   gnt_idx,
  output logic               any
);

  logic [SEL_W-1:0] cand;

  // Scan farthest-first so the closest requester to ptr overwrites the result last.
  always_comb begin
    cand    = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int k = N_LANES - 1; k >= 0; k--) begin
      cand = ptr + SEL_W'(k);
      if (req[cand]) begin
        gnt_idx = cand;
        any     = 1'b1;
      end
    end
  end

  always_comb begin
    gnt_onehot = '0;
    if (any) begin
      gnt_onehot[gnt_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/arb8way16.sv
// Eight-lane round-robin arbiter feeding a single-entry registered output
// with one-word-per-cycle throughput.
module arb8way16
  import arb8way16_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  arb8way16_if.slave   bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] src_q, src_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic [N_LANES-1:0] gnt_onehot;
  logic [SEL_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic               load_en;
  logic [WIDTH-1:0]   sel_data;
  logic [WIDTH-1:0]   lane_data [N_LANES];

  rr_pick8 u_pick (
    .req        (bus.in_valid),
    .ptr        (ptr_q),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (gnt_any)
  );

  for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
    assign lane_data[gi] = bus.in_data[lane_lo(gi, WIDTH) +: WIDTH];
  end

  assign sel_data = lane_data[gnt_idx];
  assign load_en  = (state_q == ST_EMPTY) || bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      src_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      src_q   <= src_d;
      ptr_q   <= ptr_d;
    end
  end

  // An empty cycle with no requester leaves data, source and ptr untouched.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    src_d   = src_q;
    ptr_d   = ptr_q;
    if (load_en) begin
      if (gnt_any) begin
        state_d = ST_FULL;
        data_d  = sel_data;
        src_d   = gnt_idx;
        ptr_d   = gnt_idx + SEL_W'(1);
      end else begin
        state_d = ST_EMPTY;
      end
    end
  end

  // Grant never depends on in_data, only on requests, ptr and load_en.
  always_comb begin
    bus.in_ready  = '0;
    if (load_en && gnt_any && !reset) begin
      bus.in_ready = gnt_onehot;
    end
    bus.out_valid = (state_q == ST_FULL);
    bus.out_data  = data_q;
    bus.out_src   = src_q;
  end

endmodule

// File: doc/arb8way16.md
# arb8way16

Round-robin arbiter that shares one 16-bit downstream channel between eight valid/ready requester lanes. Each cycle the block selects one valid lane, drives the internal 8-to-1 data select, and captures the chosen word into a single-entry output register, with back-to-back throughput of one word per cycle. It sits in front of any shared 16-bit consumer: ALU input, memory write port or bus bridge.

## Interface
Parameters:
- WIDTH, 16, data width per lane and of the output word.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- in_valid  in  8  per-lane request; bit i means lane i holds a word.
- in_data  in  8*WIDTH  lane i occupies bits [WIDTH*i+WIDTH-1 : WIDTH*i].
- in_ready  out  8  one-hot-or-zero; bit i high means lane i's word is consumed this cycle.
- out_valid  out  1  output register holds a word.
- out_ready  in  1  consumer accepts out_data this cycle.
- out_data  out  WIDTH  registered winning word.
- out_src  out  3  registered index of the lane that supplied out_data.

## Operation
- Two states, encoded by out_valid:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- load_en = !out_valid | out_ready. The register can accept a word when it is empty or is being drained in the same cycle.
- Round-robin pointer ptr[2:0] sets the search start. Search lanes ptr, ptr+1, … ptr+7, mod 8. The first lane with in_valid=1 wins.
- If load_en and a winner w exists:
  - in_ready[w]=1; all other in_ready bits are 0.
  - On the edge: out_data <= lane w data, out_src <= w, out_valid <= 1, ptr <= (w+1) mod 8.
- If load_en and no lane is valid:
  - in_ready = 0, out_valid <= 0.
  - out_data, out_src and ptr hold.
- If !load_en (FULL and out_ready=0):
  - in_ready = 0.
  - out_data, out_src, out_valid and ptr hold.
- in_ready is combinational from in_valid, ptr, out_valid and out_ready. No path exists from in_data to in_ready.
- Transfer rules:
  - A lane transfer occurs when in_valid[i] & in_ready[i].
  - An output transfer occurs when out_valid & out_ready.
  - out_data and out_src stay stable while out_valid=1 and out_ready=0.
- A lane that deasserts in_valid before it is granted loses nothing and is simply skipped.
- ptr wraps from 7 to 0. A sole requester is granted every cycle regardless of ptr.
- Reset values: out_valid=0, out_data=0, out_src=0, ptr=0.
- in_ready is forced to 0 while reset=1.
- Reset mid-operation discards any held word without an output transfer.

## Timing
- Latency: a lane transfer at edge N makes the word visible on out_data/out_valid after edge N.
- Throughput: one word per cycle while out_ready=1 and any lane is valid.
- Simultaneous drain and load in FULL: the old word leaves and the new word is captured on the same edge, with no bubble.
- With all eight lanes continuously valid, each lane is granted exactly once in any 8 consecutive grants.
- Reset is synchronous. The first grant can occur in the first cycle with reset=0.

## Structure
- Shared package holds:
  - N_LANES = 8.
  - SEL_W = 3.
  - The lane-slice helper used to index in_data.
- Sub-module rr_pick8:
  - Purely combinational.
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: gnt_onehot[7:0], gnt_idx[2:0], any.
- The top level holds ptr, the output register, the WIDTH-wide 8-to-1 select on gnt_idx, and the load_en logic.

## Test plan
- Reset:
  - Stimulus: assert reset for 2 cycles with all lanes valid.
  - Required: in_ready=0; after release out_valid=0, out_data=0, out_src=0. The first grant after release goes to lane 0.
- Full rotation:
  - Stimulus: all lanes valid, lane i data = 16'h1000+i, out_ready=1.
  - Required: out_src sequence 0,1,…,7,0 on consecutive cycles; out_data tracks 16'h1000+out_src.
- Sparse requests:
  - Stimulus: lanes 2 and 5 valid only, ptr=0, out_ready=1.
  - Required: grants alternate 2,5,2,5. in_ready is never set for any other lane.
- Backpressure:
  - Stimulus: out_ready=0 for 4 cycles with out_valid=1 and src=3.
  - Required: in_ready=0; out_data, out_src and ptr stable.
  - Stimulus: then raise out_ready=1.
  - Required: the next lane (4 if valid) is granted in that same cycle.
- Wrap and drain:
  - Stimulus: only lane 7 valid for one grant, then only lane 0.
  - Required: ptr goes 0→0 (7+1 wraps to 0) and lane 0 is granted next. With no requests, out_valid drops one cycle after the final drain.
- Reset mid-operation:
  - Stimulus: assert reset while FULL with out_ready=0.
  - Required: out_valid=0 next cycle, the word is never transferred, ptr=0.
